// File: rtl/nd_1to2_pkg.sv
// Shared types and default sizes for the 1-to-2 routing splitter.
package nd_1to2_pkg;

   localparam int unsigned NS_MESSAGE_FIFO_SIZE = 4;
   localparam int unsigned NS_ADDRESS_SIZE      = 8;
   localparam int unsigned NS_DATA_SIZE         = 8;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } node_state_e;

   // Pointer width carries one extra wrap bit so full and empty differ.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/nd_1to2_ns_msg_fifo.sv
// Message FIFO (ns_msg_fifo): head/tail pointers with a wrap bit, read data
// presented combinationally from the tail entry.
module ns_msg_fifo
   import nd_1to2_pkg::*;
#(
   parameter int unsigned FSZ = NS_MESSAGE_FIFO_SIZE,
   parameter int unsigned ASZ = NS_ADDRESS_SIZE,
   parameter int unsigned DSZ = NS_DATA_SIZE
) (
   input  logic                     i_clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [2*ASZ+DSZ-1:0]     din,
   output logic [2*ASZ+DSZ-1:0]     dout,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = ptr_width(FSZ);
   localparam int unsigned AW = PW - 1;
   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

   logic [2*ASZ+DSZ-1:0] mem [FSZ];
   logic [PW-1:0]        head;
   logic [PW-1:0]        tail;

   assign empty = (head == tail);
   assign full  = (head[PW-1] != tail[PW-1]) && (head[AW-1:0] == tail[AW-1:0]);
   assign dout  = mem[tail[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (reset || clr) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (wr_en && !full)
            head <= head + PTR_ONE;
         if (rd_en && !empty)
            tail <= tail + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en && !full)
         mem[head[AW-1:0]] <= din;
   end

endmodule

// File: rtl/nd_1to2.sv
// 1-to-2 routing splitter: one 4-phase input steered by dst into two FIFOs,
// each draining onto its own 4-phase output. Optional counters: ND_1TO2_CNT_EN.
module nd_1to2
   import nd_1to2_pkg::*;
#(
   parameter int unsigned FSZ = NS_MESSAGE_FIFO_SIZE,
   parameter int unsigned ASZ = NS_ADDRESS_SIZE,
   parameter int unsigned DSZ = NS_DATA_SIZE
) (
   input  logic           i_clk,
   input  logic           reset,
   output logic           ready,
   input  logic [ASZ-1:0] rcv0_src,
   input  logic [ASZ-1:0] rcv0_dst,
   input  logic [DSZ-1:0] rcv0_dat,
   input  logic           rcv0_req,
   output logic           rcv0_ack,
   output logic [ASZ-1:0] snd0_src,
   output logic [ASZ-1:0] snd0_dst,
   output logic [DSZ-1:0] snd0_dat,
   output logic           snd0_req,
   input  logic           snd0_ack,
   output logic [ASZ-1:0] snd1_src,
   output logic [ASZ-1:0] snd1_dst,
   output logic [DSZ-1:0] snd1_dat,
   output logic           snd1_req,
   input  logic           snd1_ack
`ifdef ND_1TO2_CNT_EN
   ,
   output logic [15:0]    cnt0,
   output logic [15:0]    cnt1
`endif
);

   localparam int unsigned MW = 2*ASZ + DSZ;
   localparam logic [ASZ-1:0] SPLIT = {1'b1, {(ASZ-1){1'b0}}};

   node_state_e state, state_nx;
   logic          init;
   logic          sel, tgt_full, accept;
   logic          wr0, wr1, rd0, rd1;
   logic          full0, full1, empty0, empty1;
   logic [MW-1:0] din, dout0, dout1;

   assign ready = (state == ST_RUN);
   assign init  = (state == ST_INIT);
   assign din   = {rcv0_src, rcv0_dst, rcv0_dat};

   always_ff @(posedge i_clk) begin
      if (reset)
         state <= ST_INIT;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == ST_INIT)
         state_nx = ST_RUN;
   end

   always_comb begin
      sel      = (rcv0_dst >= SPLIT);
      tgt_full = sel ? full1 : full0;
      accept   = ready && rcv0_req && !rcv0_ack && !tgt_full;
      wr0      = accept && !sel;
      wr1      = accept && sel;
      rd0      = ready && !snd0_req && !snd0_ack && !empty0;
      rd1      = ready && !snd1_req && !snd1_ack && !empty1;
   end

   ns_msg_fifo #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ)) u_fifo0 (
      .i_clk(i_clk), .reset(reset), .clr(init),
      .wr_en(wr0), .rd_en(rd0), .din(din),
      .dout(dout0), .full(full0), .empty(empty0)
   );

   ns_msg_fifo #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ)) u_fifo1 (
      .i_clk(i_clk), .reset(reset), .clr(init),
      .wr_en(wr1), .rd_en(rd1), .din(din),
      .dout(dout1), .full(full1), .empty(empty1)
   );

   // Init cycle behaves like reset so no channel moves until ready is high.
   always_ff @(posedge i_clk) begin
      if (reset || init) begin
         rcv0_ack <= 1'b0;
         snd0_req <= 1'b0;
         snd1_req <= 1'b0;
         {snd0_src, snd0_dst, snd0_dat} <= '0;
         {snd1_src, snd1_dst, snd1_dat} <= '0;
`ifdef ND_1TO2_CNT_EN
         cnt0 <= '0;
         cnt1 <= '0;
`endif
      end else begin
         if (accept)
            rcv0_ack <= 1'b1;
         else if (!rcv0_req && rcv0_ack)
            rcv0_ack <= 1'b0;

         if (rd0) begin
            {snd0_src, snd0_dst, snd0_dat} <= dout0;
            snd0_req <= 1'b1;
         end else if (snd0_req && snd0_ack) begin
            snd0_req <= 1'b0;
         end

         if (rd1) begin
            {snd1_src, snd1_dst, snd1_dat} <= dout1;
            snd1_req <= 1'b1;
         end else if (snd1_req && snd1_ack) begin
            snd1_req <= 1'b0;
         end
`ifdef ND_1TO2_CNT_EN
         if (snd0_req && snd0_ack)
            cnt0 <= cnt0 + 16'd1;
         if (snd1_req && snd1_ack)
            cnt1 <= cnt1 + 16'd1;
`endif
      end
   end

endmodule

// File: tb/tb_nd_1to2.sv
// Directed, table-driven bench for nd_1to2 (FSZ=4, ASZ=8, DSZ=8).
module tb_nd_1to2;

   logic       i_clk = 1'b0;
   logic       reset = 1'b1;
   logic       ready;
   logic [7:0] rcv0_src = '0, rcv0_dst = '0, rcv0_dat = '0;
   logic       rcv0_req = 1'b0;
   logic       rcv0_ack;
   logic [7:0] snd0_src, snd0_dst, snd0_dat;
   logic       snd0_req;
   logic       snd0_ack = 1'b0;
   logic [7:0] snd1_src, snd1_dst, snd1_dat;
   logic       snd1_req;
   logic       snd1_ack = 1'b0;
`ifdef ND_1TO2_CNT_EN
   logic [15:0] cnt0, cnt1;
`endif

   nd_1to2 #(.FSZ(4), .ASZ(8), .DSZ(8)) dut (
      .i_clk(i_clk), .reset(reset), .ready(ready),
      .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat),
      .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
      .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat),
      .snd0_req(snd0_req), .snd0_ack(snd0_ack),
      .snd1_src(snd1_src), .snd1_dst(snd1_dst), .snd1_dat(snd1_dat),
      .snd1_req(snd1_req), .snd1_ack(snd1_ack)
`ifdef ND_1TO2_CNT_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;
   bit auto0 = 1'b0, auto1 = 1'b0;
   bit p0 = 1'b0, p1 = 1'b0;
   logic [23:0] q0[$], q1[$], e0[$], e1[$];

   typedef struct {
      logic [7:0] src;
      logic [7:0] dst;
      logic [7:0] dat;
      bit         port;
   } vec_t;
   vec_t tbl[8];

   // Zero-wait downstream peers: ack mirrors req one step after each edge.
   always @(posedge i_clk) begin
      #1;
      snd0_ack = auto0 ? snd0_req : 1'b0;
      snd1_ack = auto1 ? snd1_req : 1'b0;
   end

   always @(negedge i_clk) begin
      if (snd0_req && !p0) q0.push_back({snd0_src, snd0_dst, snd0_dat});
      if (snd1_req && !p1) q1.push_back({snd1_src, snd1_dst, snd1_dat});
      p0 = snd0_req;
      p1 = snd1_req;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] s, input logic [7:0] d, input logic [7:0] v,
                       output bit acked);
      bit dropped;
      acked = 1'b0;
      dropped = 1'b0;
      rcv0_src = s; rcv0_dst = d; rcv0_dat = v; rcv0_req = 1'b1;
      for (int n = 0; n < 50 && !acked; n++) begin
         cyc(1);
         if (rcv0_ack) acked = 1'b1;
      end
      rcv0_req = 1'b0;
      if (acked) begin
         for (int n = 0; n < 50 && !dropped; n++) begin
            cyc(1);
            if (!rcv0_ack) dropped = 1'b1;
         end
         chk("ack_release", dropped, 1'b1);
      end
   endtask

   task automatic cmp_queues(input string nm);
      chk({nm, "_cnt0"}, q0.size(), e0.size());
      chk({nm, "_cnt1"}, q1.size(), e1.size());
      foreach (e0[i]) chk({nm, "_msg0"}, (i < q0.size()) ? {8'h00, q0[i]} : 32'hDEAD_BEEF, {8'h00, e0[i]});
      foreach (e1[i]) chk({nm, "_msg1"}, (i < q1.size()) ? {8'h00, q1[i]} : 32'hDEAD_BEEF, {8'h00, e1[i]});
   endtask

   task automatic clear_q();
      q0.delete(); q1.delete(); e0.delete(); e1.delete();
   endtask

   initial begin
      bit ok;
      tbl[0] = '{8'h01, 8'd5,   8'h11, 1'b0};
      tbl[1] = '{8'h02, 8'd128, 8'h22, 1'b1};
      tbl[2] = '{8'h03, 8'd255, 8'h33, 1'b1};
      tbl[3] = '{8'h04, 8'd127, 8'h44, 1'b0};
      tbl[4] = '{8'h05, 8'd0,   8'h55, 1'b0};
      tbl[5] = '{8'h06, 8'd129, 8'h66, 1'b1};
      tbl[6] = '{8'h07, 8'd64,  8'h77, 1'b0};
      tbl[7] = '{8'h08, 8'd200, 8'h88, 1'b1};

      // Reset held for three cycles, then the init cycle.
      cyc(3);
      chk("rst_ready", ready, 1'b0);
      chk("rst_ack", rcv0_ack, 1'b0);
      chk("rst_req0", snd0_req, 1'b0);
      chk("rst_req1", snd1_req, 1'b0);
      chk("rst_fields", {snd0_dst, snd0_dat, snd1_dst, snd1_dat}, 32'h0);
      reset = 1'b0;
      chk("init_ready_pre", ready, 1'b0);
      cyc(1);
      chk("init_ready", ready, 1'b1);
      chk("init_reqs", {rcv0_ack, snd0_req, snd1_req}, 3'b000);

      // Latency: dst=5 shows on snd0 two edges after req rises.
      auto0 = 1'b1; auto1 = 1'b1;
      rcv0_src = 8'h09; rcv0_dst = 8'd5; rcv0_dat = 8'hA1; rcv0_req = 1'b1;
      cyc(1);
      chk("lat_ack", rcv0_ack, 1'b1);
      chk("lat_req0_early", snd0_req, 1'b0);
      cyc(1);
      chk("lat_req0", snd0_req, 1'b1);
      chk("lat_dst", snd0_dst, 8'd5);
      chk("lat_dat", snd0_dat, 8'hA1);
      chk("lat_req1", snd1_req, 1'b0);
      rcv0_req = 1'b0;
      cyc(6);

      // Routing table including both sides of the split boundary.
      clear_q();
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].src, tbl[i].dst, tbl[i].dat, ok);
         chk("tbl_ack", ok, 1'b1);
         if (tbl[i].port) e1.push_back({tbl[i].src, tbl[i].dst, tbl[i].dat});
         else             e0.push_back({tbl[i].src, tbl[i].dst, tbl[i].dat});
      end
      cyc(10);
      cmp_queues("tbl");

      // Output 0 stalled: FSZ+1 accepted, next blocked, output 1 still flows.
      clear_q();
      auto0 = 1'b0;
      cyc(2);
      for (int i = 0; i < 5; i++) begin
         send(8'h10, 8'd10 + 8'(i), 8'hB0 + 8'(i), ok);
         chk("full_ack", ok, 1'b1);
         e0.push_back({8'h10, 8'd10 + 8'(i), 8'hB0 + 8'(i)});
      end
      rcv0_src = 8'h10; rcv0_dst = 8'd20; rcv0_dat = 8'hBF; rcv0_req = 1'b1;
      cyc(8);
      chk("full_block", rcv0_ack, 1'b0);
      chk("full_hold_req0", snd0_req, 1'b1);
      rcv0_req = 1'b0;
      cyc(1);
      send(8'h11, 8'd200, 8'hC0, ok);
      chk("full_other_ack", ok, 1'b1);
      e1.push_back({8'h11, 8'd200, 8'hC0});
      cyc(4);
      chk("full_other_cnt", q1.size(), 1);
      auto0 = 1'b1;
      cyc(20);
      cmp_queues("full");

      // Reset while snd1 busy and FIFO 1 non-empty.
      auto1 = 1'b0;
      send(8'h20, 8'd130, 8'hD0, ok);
      chk("mid_ack_a", ok, 1'b1);
      send(8'h21, 8'd131, 8'hD1, ok);
      chk("mid_ack_b", ok, 1'b1);
      chk("mid_req1", snd1_req, 1'b1);
      reset = 1'b1;
      cyc(1);
      chk("mid_rst_req1", snd1_req, 1'b0);
      chk("mid_rst_ready", ready, 1'b0);
      chk("mid_rst_fields", {snd1_src, snd1_dst, snd1_dat}, 24'h0);
      reset = 1'b0;
      cyc(1);
      chk("mid_reinit", ready, 1'b1);
      clear_q();
      auto1 = 1'b1;
      cyc(20);
      cmp_queues("stale");

      // Twenty interleaved messages with zero-wait peers.
      clear_q();
      for (int i = 0; i < 20; i++) begin
         logic [7:0] d;
         d = (i % 2 == 1) ? 8'h80 + 8'(i * 3) : 8'(i * 5);
         send(8'(i), d, 8'h30 + 8'(i), ok);
         chk("il_ack", ok, 1'b1);
         if (i % 2 == 1) e1.push_back({8'(i), d, 8'h30 + 8'(i)});
         else            e0.push_back({8'(i), d, 8'h30 + 8'(i)});
      end
      cyc(20);
      cmp_queues("il");
`ifdef ND_1TO2_CNT_EN
      chk("cnt_sum", 32'(cnt0) + 32'(cnt1), 32'd20);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
